// File: rtl/tlut_prod_gen.sv
// Temporal-LUT product generator: sweeps a shared time counter, captures running ramps into prod[j][i] = b[j]*a[i].
// Optional build macro EARLY_EXIT_EN ends the sweep after the largest B value instead of the full 2^W range.
module tlut_prod_gen #(
    parameter int DIM_ROW1   = 2,
    parameter int DIM_COL1   = 2,
    parameter int DIM_ROW2   = 2,
    parameter int DIM_COL2   = 2,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                                                             clk,
    input  logic                                                             rst_n,
    input  logic                                                             in_valid,
    output logic                                                             in_ready,
    input  logic [DIM_ROW1*DIM_COL1-1:0][DATA_WIDTH-1:0]                     a_in,
    input  logic [DIM_ROW2*DIM_COL2-1:0][DATA_WIDTH-1:0]                     b_in,
    output logic [DIM_ROW2*DIM_COL2-1:0][DIM_ROW1*DIM_COL1-1:0][ACC_WIDTH-1:0] prod,
    output logic                                                             prod_valid,
    input  logic                                                             prod_ready
);
    localparam int NA = DIM_ROW1 * DIM_COL1;
    localparam int NB = DIM_ROW2 * DIM_COL2;
    localparam int W  = DATA_WIDTH;

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                                   state_q, state_d;
    logic [W:0]                               t_q, t_d;
    logic [NA-1:0][W-1:0]                     a_q, a_d;
    logic [NB-1:0][W-1:0]                     b_q, b_d;
    logic [NA-1:0][ACC_WIDTH-1:0]             ramp_q, ramp_d;
    logic [NB-1:0]                            cap_q, cap_d;
    logic [NB-1:0][NA-1:0][ACC_WIDTH-1:0]     prod_q, prod_d;
    logic                                     sweep_end;

`ifdef EARLY_EXIT_EN
    logic [W-1:0] bmax_q, bmax_d, bmax_in;

    always_comb begin
        bmax_in = '0;
        for (int j = 0; j < NB; j++) begin
            if (b_in[j] > bmax_in) bmax_in = b_in[j];
        end
    end

    // The last capture happens at t == bmax; the following cycle hands over to DONE.
    assign sweep_end = (t_q == ({1'b0, bmax_q} + (W+1)'(1)));
`else
    // t is one bit wider than the operands, so its MSB flags that every value 0..2^W-1 has been swept.
    assign sweep_end = t_q[W];
`endif

    always_comb begin
        // NOTE: every combinational output gets its hold value first, so no branch can leave a latch behind.
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        ramp_d  = ramp_q;
        cap_d   = cap_q;
        prod_d  = prod_q;
`ifdef EARLY_EXIT_EN
        bmax_d  = bmax_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    t_d     = '0;
                    ramp_d  = '0;
                    cap_d   = '0;
                    state_d = SWEEP;
`ifdef EARLY_EXIT_EN
                    bmax_d  = bmax_in;
`endif
                end
            end
            SWEEP: begin
                if (sweep_end) begin
                    state_d = DONE;
                end else begin
                    for (int j = 0; j < NB; j++) begin
                        if (({1'b0, b_q[j]} == t_q) && !cap_q[j]) begin
                            prod_d[j] = ramp_q;
                            cap_d[j]  = 1'b1;
                        end
                    end
                    for (int i = 0; i < NA; i++) begin
                        ramp_d[i] = ramp_q[i] + ACC_WIDTH'(a_q[i]);
                    end
                    t_d = t_q + (W+1)'(1);
                end
            end
            DONE: begin
                if (prod_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: prod is a visible output that must read zero after reset, so this storage array is reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ramp_q  <= '0;
            cap_q   <= '0;
            prod_q  <= '0;
`ifdef EARLY_EXIT_EN
            bmax_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ramp_q  <= ramp_d;
            cap_q   <= cap_d;
            prod_q  <= prod_d;
`ifdef EARLY_EXIT_EN
            bmax_q  <= bmax_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign prod_valid = (state_q == DONE);
    assign prod       = prod_q;

endmodule

// File: tb/tb_tlut_prod_gen.sv
// Randomised self-checking bench for tlut_prod_gen; expected products and latencies come from plain arithmetic.
// Define EARLY_EXIT_EN for both bench and RTL to exercise the early-exit build.
module tb_tlut_prod_gen;
    localparam int NA  = 4;
    localparam int NB  = 4;
    localparam int W   = 4;
    localparam int ACC = 16;
    localparam int PW  = NB * NA * ACC;

    typedef logic [NA-1:0][W-1:0] a_vec_t;
    typedef logic [NB-1:0][W-1:0] b_vec_t;
    typedef logic [NB-1:0][NA-1:0][ACC-1:0] prod_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    logic   in_ready;
    a_vec_t a_in;
    b_vec_t b_in;
    prod_t  prod;
    logic   prod_valid;
    logic   prod_ready;

    int n_checks = 0;
    int n_fail   = 0;

    tlut_prod_gen #(
        .DIM_ROW1(2), .DIM_COL1(2), .DIM_ROW2(2), .DIM_COL2(2),
        .DATA_WIDTH(W), .ACC_WIDTH(ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NA-1:0][W-1:0] mk(input int v0, input int v1, input int v2, input int v3);
        logic [NA-1:0][W-1:0] v;
        v[0] = W'(v0); v[1] = W'(v1); v[2] = W'(v2); v[3] = W'(v3);
        return v;
    endfunction

    function automatic prod_t model_prod(input a_vec_t a, input b_vec_t b);
        prod_t p;
        for (int j = 0; j < NB; j++)
            for (int i = 0; i < NA; i++)
                p[j][i] = ACC'(int'(b[j]) * int'(a[i]));
        return p;
    endfunction

    // Edges from the accept edge to the edge where prod_valid rises.
    function automatic int exp_lat(input b_vec_t b);
`ifdef EARLY_EXIT_EN
        int m = 0;
        for (int j = 0; j < NB; j++) if (int'(b[j]) > m) m = int'(b[j]);
        return m + 2;
`else
        return (1 << W) + 1;
`endif
    endfunction

    task automatic check_prod(input string tag, input a_vec_t a, input b_vec_t b);
        prod_t e;
        e = model_prod(a, b);
        for (int j = 0; j < NB; j++)
            for (int i = 0; i < NA; i++)
                check($sformatf("%s_p%0d%0d", tag, j, i), PW'(prod[j][i]), PW'(e[j][i]));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        check({tag, "_ready_wait"}, PW'(in_ready), PW'(1));
    endtask

    // One transaction with random noise on the inputs while busy and `hold` cycles of backpressure.
    task automatic run_txn(input string tag, input a_vec_t a, input b_vec_t b, input int hold);
        int   n;
        logic busy_bad;
        prod_t e;
        e = model_prod(a, b);
        prod_ready = 1'b0;
        wait_ready(tag);
        a_in = a; b_in = b; in_valid = 1'b1;
        tick();
        busy_bad = 1'b0;
        n = 0;
        while (!prod_valid && n < 200) begin
            busy_bad |= in_ready;
            in_valid = 1'($urandom_range(0, 1));
            a_in = a_vec_t'($urandom);
            b_in = b_vec_t'($urandom);
            tick();
            n++;
        end
        check({tag, "_latency"}, PW'(n), PW'(exp_lat(b)));
        check_prod(tag, a, b);
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_in = a_vec_t'($urandom);
            tick();
            busy_bad |= in_ready | !prod_valid | (prod !== e);
        end
        check({tag, "_busy_stable"}, PW'(busy_bad), PW'(0));
        in_valid = 1'b0;
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        check({tag, "_handoff_valid"}, PW'(prod_valid), PW'(0));
        check({tag, "_handoff_ready"}, PW'(in_ready), PW'(1));
        check({tag, "_prod_kept"}, PW'(prod), PW'(e));
    endtask

    initial begin
        a_vec_t a1, a2;
        b_vec_t b1, b2;
        int     cyc, got, t1;

        rst_n = 1'b0; in_valid = 1'b0; prod_ready = 1'b0; a_in = '0; b_in = '0;
        #12;
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_prod_valid", PW'(prod_valid), PW'(0));
        check("rst_prod", PW'(prod), PW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_txn("basic", mk(3, 5, 7, 15), mk(0, 1, 2, 15), 0);
        run_txn("extreme", mk(15, 15, 0, 1), mk(15, 15, 15, 15), 0);
        run_txn("backpressure", mk(9, 2, 11, 4), mk(6, 3, 12, 1), 10);
        run_txn("early", mk(4, 8, 12, 13), mk(1, 2, 3, 0), 1);
        run_txn("all_zero_b", mk(7, 1, 9, 14), mk(0, 0, 0, 0), 2);

        // Back-to-back with prod_ready and in_valid held high.
        a1 = mk(2, 4, 6, 8);   b1 = mk(3, 1, 4, 9);
        a2 = mk(11, 13, 1, 5); b2 = mk(7, 14, 2, 5);
        wait_ready("b2b");
        prod_ready = 1'b1;
        a_in = a1; b_in = b1; in_valid = 1'b1;
        tick();
        a_in = a2; b_in = b2;
        cyc = 0; got = 0; t1 = 0;
        while (got < 2 && cyc < 300) begin
            tick();
            cyc++;
            if (prod_valid) begin
                if (got == 0) begin
                    check("b2b_lat1", PW'(cyc), PW'(exp_lat(b1)));
                    check("b2b_prod1", PW'(prod), PW'(model_prod(a1, b1)));
                    t1 = cyc;
                end else begin
                    in_valid = 1'b0;
                    check("b2b_spacing", PW'(cyc - t1), PW'(exp_lat(b2) + 2));
                    check("b2b_prod2", PW'(prod), PW'(model_prod(a2, b2)));
                end
                got++;
            end
        end
        check("b2b_count", PW'(got), PW'(2));
        in_valid = 1'b0;
        tick();
        prod_ready = 1'b0;

        // Reset in the middle of a sweep.
        wait_ready("midrst");
        a_in = mk(5, 6, 7, 8); b_in = mk(15, 14, 13, 12); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_prod", PW'(prod), PW'(0));
        check("midrst_valid", PW'(prod_valid), PW'(0));
        check("midrst_ready", PW'(in_ready), PW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_txn("after_rst", mk(12, 3, 10, 6), mk(9, 0, 15, 4), 0);

        for (int k = 0; k < 6; k++)
            run_txn($sformatf("rand%0d", k), a_vec_t'($urandom), b_vec_t'($urandom),
                    int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end
endmodule
